// File: rtl/ram_init_pkg.sv
// Shared definitions for the RAM request initiator: controller state
// encoding and default address/data widths.
// Build option: RAM_INIT_READBACK_EN adds the write read-back states.
package ram_init_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
`ifdef RAM_INIT_READBACK_EN
    ,
    S_RB_SETUP,
    S_RB_STROBE,
    S_RB_HOLD
`endif
  } state_t;

endpackage

// File: rtl/ram_addr_ctr.sv
// Burst address/beat tracker: loadable address register that wraps modulo
// 2^AW on increment, plus a down-counting beat counter with a zero flag.
module ram_addr_ctr
  import ram_init_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_len,
  input  logic          i_step,
  output logic [AW-1:0] o_addr,
  output logic          o_zero
);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_cnt;

  // Load on request accept; advance one beat on each non-final response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_cnt  <= i_len;
    end else if (i_step) begin
      r_addr <= r_addr + 1'b1;
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ram_initiator.sv
// Request-side controller for latch-based 16-bit word RAMs. Sequences
// select/address/data around a single-cycle enable strobe per beat and
// returns one response per beat over a valid/ready handshake.
// Build option: RAM_INIT_READBACK_EN re-reads each written word and flags
// mismatches on rsp_err.
module ram_initiator
  import ram_init_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_last,
  output logic          ram_r,
  output logic          ram_w,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  output logic          ram_en,
  input  logic [DW-1:0] ram_o
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_we;
  logic [DW-1:0] r_ram_d;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          r_ram_r;
  logic          r_ram_w;
  logic          r_ram_en;
  logic          w_accept;
  logic          w_step;
  logic          w_cnt_zero;
  logic [AW-1:0] w_addr;
  logic          w_we_nxt;
  logic          w_r_nxt;
  logic          w_w_nxt;
  logic          w_en_nxt;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_step   = (r_state == S_RESP) && rsp_ready && !w_cnt_zero;

  ram_addr_ctr #(.AW(AW)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_addr (req_addr),
    .i_len  (req_len),
    .i_step (w_step),
    .o_addr (w_addr),
    .o_zero (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, plus RAM strobe/select values decoded from the next state so
  // the RAM pins come straight from flops and never glitch.
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_r_nxt     = 1'b0;
    w_w_nxt     = 1'b0;
    w_en_nxt    = 1'b0;
    if (r_state == S_IDLE) w_we_nxt = req_we;
    case (r_state)
      S_IDLE:      if (req_valid) w_state_nxt = S_SETUP;
      S_SETUP:     w_state_nxt = S_STROBE;
      S_STROBE:    w_state_nxt = S_HOLD;
`ifdef RAM_INIT_READBACK_EN
      S_HOLD:      w_state_nxt = r_we ? S_RB_SETUP : S_RESP;
      S_RB_SETUP:  w_state_nxt = S_RB_STROBE;
      S_RB_STROBE: w_state_nxt = S_RB_HOLD;
      S_RB_HOLD:   w_state_nxt = S_RESP;
`else
      S_HOLD:      w_state_nxt = S_RESP;
`endif
      S_RESP:      if (rsp_ready) w_state_nxt = w_cnt_zero ? S_IDLE : S_SETUP;
      default:     w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_SETUP, S_STROBE, S_HOLD: begin
        w_r_nxt = !w_we_nxt;
        w_w_nxt = w_we_nxt;
      end
`ifdef RAM_INIT_READBACK_EN
      S_RB_SETUP, S_RB_STROBE, S_RB_HOLD: w_r_nxt = 1'b1;
`endif
      default: ;
    endcase
`ifdef RAM_INIT_READBACK_EN
    w_en_nxt = (w_state_nxt == S_STROBE) || (w_state_nxt == S_RB_STROBE);
`else
    w_en_nxt = (w_state_nxt == S_STROBE);
`endif
  end

  // RAM select and strobe flops; all drop together on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_r  <= 1'b0;
      r_ram_w  <= 1'b0;
      r_ram_en <= 1'b0;
    end else begin
      r_ram_r  <= w_r_nxt;
      r_ram_w  <= w_w_nxt;
      r_ram_en <= w_en_nxt;
    end
  end

  // Latch request type and fill data; ram_d keeps its value across reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_ram_d <= '0;
    end else if (w_accept) begin
      r_we <= req_we;
      if (req_we) r_ram_d <= req_wdata;
    end
  end

  // Capture response data on the edge that closes each strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_STROBE) begin
        r_rdata <= r_we ? '0 : ram_o;
        r_err   <= 1'b0;
      end
`ifdef RAM_INIT_READBACK_EN
      if (r_state == S_RB_STROBE) begin
        r_rdata <= ram_o;
        r_err   <= (ram_o != r_ram_d);
      end
`endif
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_last  = (r_state == S_RESP) && w_cnt_zero;
  assign rsp_we    = r_we;
  assign rsp_addr  = w_addr;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign ram_r     = r_ram_r;
  assign ram_w     = r_ram_w;
  assign ram_en    = r_ram_en;
  assign ram_addr  = w_addr;
  assign ram_d     = r_ram_d;

endmodule

// File: tb/tb_ram_initiator.sv
// Bench for ram_initiator: directed test-plan steps followed by random
// requests, checked against a word-array model of the RAM contents.
`timescale 1ns/1ps
module tb_ram_initiator;

  localparam int AW = 4;
  localparam int DW = 16;
`ifdef RAM_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_last;
  logic          ram_r;
  logic          ram_w;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic          ram_en;
  logic [DW-1:0] ram_o;

  ram_initiator #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_last(rsp_last),
    .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_d(ram_d),
    .ram_en(ram_en), .ram_o(ram_o)
  );

  always #5 clk = ~clk;

  // RAM device: stores on the enable strobe, drives data only while read
  // is selected; rd_mask models stuck-at-0 output bits.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_mask = 16'hFFFF;
  assign ram_o = ram_r ? (mem[ram_addr] & rd_mask) : 'x;
  always @(posedge clk) if (ram_en && ram_w) mem[ram_addr] <= ram_d;

  // Bus monitor.
  int en_cycles = 0;
  int bus_viol  = 0;
  always @(negedge clk) begin
    if (ram_en === 1'b1) en_cycles++;
    if ((ram_r && ram_w) || (ram_en && !(ram_r || ram_w))) bus_viol++;
  end

  // Reference contents of the RAM.
  logic [DW-1:0] ref_mem [16];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic run_req(input logic we, input logic [3:0] addr, input logic [3:0] len,
                         input logic [15:0] wdata, input int stall_beat, input int stall_cyc);
    int en0;
    int lat;
    int exp_lat;
    int exp_en;
    logic [3:0]  a;
    logic [15:0] er;
    logic        ee;
    logic [22:0] snap;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wdata;
    en0 = en_cycles;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 4'($urandom); req_len = 4'($urandom);
    req_wdata = 16'($urandom);
    chk("req_ready_busy", 64'(req_ready), 64'(0));
    exp_lat = (we && RB) ? 6 : 3;
    for (int b = 0; b <= int'(len); b++) begin
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("rsp_latency", 64'(lat), 64'(exp_lat));
      a = addr + 4'(b);
      if (!we)     er = ref_mem[a] & rd_mask;
      else if (RB) er = wdata & rd_mask;
      else         er = '0;
      ee = we && RB && (er != wdata);
      if (b == stall_beat) begin
        snap = {rsp_we, rsp_addr, rsp_rdata, rsp_last, rsp_err};
        repeat (stall_cyc) begin
          @(negedge clk);
          chk("stall_stable", 64'({rsp_valid, rsp_we, rsp_addr, rsp_rdata, rsp_last, rsp_err}),
              64'({1'b1, snap}));
          chk("stall_quiet", 64'({ram_en, req_ready}), 64'(0));
        end
      end
      chk("rsp_addr", 64'(rsp_addr), 64'(a));
      chk("rsp_we", 64'(rsp_we), 64'(we));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(er));
      chk("rsp_err", 64'(rsp_err), 64'(ee));
      chk("rsp_last", 64'(rsp_last), 64'(b == int'(len)));
      chk("rdata_known", 64'($isunknown(rsp_rdata)), 64'(0));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (we) ref_mem[a] = wdata;
    end
    chk("req_ready_after", 64'(req_ready), 64'(1));
    exp_en = (int'(len) + 1) * ((we && RB) ? 2 : 1);
    chk("en_cycles", 64'(en_cycles - en0), 64'(exp_en));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({req_ready, rsp_valid, rsp_we, rsp_last, rsp_err, ram_r, ram_w, ram_en}),
        64'(8'b1000_0000));
    chk("reset_data", 64'({rsp_addr, rsp_rdata, ram_addr, ram_d}), 64'(0));
    rst = 1'b0;

    // Clear the whole array with one 16-beat fill so every word is defined.
    run_req(1'b1, 4'd0, 4'd15, 16'h0000, -1, 0);

    run_req(1'b1, 4'd15, 4'd0, 16'd64, -1, 0);
    run_req(1'b0, 4'd15, 4'd0, 16'h0, -1, 0);
    run_req(1'b1, 4'd11, 4'd0, 16'd78, -1, 0);
    run_req(1'b0, 4'd11, 4'd0, 16'h0, -1, 0);
    run_req(1'b0, 4'd15, 4'd0, 16'h0, -1, 0);

    run_req(1'b1, 4'd14, 4'd3, 16'hA5A5, -1, 0);
    run_req(1'b0, 4'd14, 4'd3, 16'h0, -1, 0);
    run_req(1'b0, 4'd14, 4'd3, 16'h0, 1, 5);

    // Reset while the strobe is high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd15; req_len = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("strobe_before_rst", 64'(ram_en), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid", 64'({ram_en, rsp_valid, req_ready, ram_r}), 64'(4'b0010));
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b0, 4'd15, 4'd0, 16'h0, -1, 0);

`ifdef RAM_INIT_READBACK_EN
    rd_mask = 16'hFFF7;
    run_req(1'b1, 4'd3, 4'd0, 16'h0008, -1, 0);
    run_req(1'b1, 4'd4, 4'd0, 16'h0001, -1, 0);
    rd_mask = 16'hFFFF;
`endif

    for (int k = 0; k < 25; k++) begin
      run_req(1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
              int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 3)));
    end

    chk("bus_exclusive", 64'(bus_viol), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
